sonar_scan: RTL and testbench



---
 rtl/sonar_scan.sv | 199 +++++++++++++++++++
 tb/tb_sonar_scan.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_scan.sv
// Multi-channel ultrasonic ranging sequencer: fires one trigger at a time and
// times each synchronized echo pulse in pluse_us strobes.
module sonar_scan #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned W          = 16,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned TIMEOUT_US = 30000,
  parameter int unsigned GAP_US     = 50
) (
  input  logic           clk_sys,
  input  logic           rst,
  input  logic           pluse_us,
  input  logic [NCH-1:0] ch_mask,
  input  logic           fire_measure,
  input  logic           cont_en,
  output logic [NCH-1:0] trig,
  input  logic [NCH-1:0] echo,
  output logic           busy,
  output logic           done_measure,
  output logic [2:0]     ch_measure,
  output logic [1:0]     err_measure,
  output logic [W-1:0]   data_measure
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [W-1:0] TRIG_LAST = W'(TRIG_US - 1);
  localparam logic [W-1:0] TO_LAST   = W'(TIMEOUT_US - 1);
  localparam logic [W-1:0] TO_VAL    = W'(TIMEOUT_US);
  localparam logic [W-1:0] GAP_LAST  = W'(GAP_US - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, TRIG, WAIT_RISE, MEASURE, REPORT, GAP
  } state_t;

  state_t         state_q, state_d;
  logic [NCH-1:0] e1_q, es_q, esp_q;
  logic [NCH-1:0] mask_q, mask_d;
  logic [2:0]     cur_q, cur_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [2:0]     ch_q, ch_d;
  logic [1:0]     err_q, err_d;
  logic [W-1:0]   data_q, data_d;

  logic [IW-1:0]  cur_ix;
  logic           es_cur, rise;
  logic           hi_found;
  logic [2:0]     hi_idx, lo_idx;

  assign cur_ix = IW'(cur_q);
  assign es_cur = es_q[cur_ix];
  // Rising edge, so an echo already high when WAIT_RISE is entered times out.
  assign rise   = es_q[cur_ix] & ~esp_q[cur_ix];

  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = NCH; i > 0; i--) begin
      if (mask_q[i-1] && (3'(i - 1) > cur_q)) begin
        hi_found = 1'b1;
        hi_idx   = 3'(i - 1);
      end
      if (ch_mask[i-1]) lo_idx = 3'(i - 1);
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    err_d   = err_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if ((fire_measure || cont_en) && (ch_mask != '0)) begin
          state_d = CHECK;
          mask_d  = ch_mask;
          cur_d   = lo_idx;
        end
      end
      CHECK: begin
        cnt_d = '0;
        if (es_cur) begin
          state_d = REPORT;
          ch_d    = cur_q;
          err_d   = 2'd1;
          data_d  = '0;
        end else begin
          state_d = TRIG;
        end
      end
      TRIG: begin
        if (pluse_us) begin
          if (cnt_q == TRIG_LAST) begin
            state_d = WAIT_RISE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end else if (pluse_us) begin
          if (cnt_q == TO_LAST) begin
            state_d = REPORT;
            ch_d    = cur_q;
            err_d   = 2'd2;
            data_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      MEASURE: begin
        if (!es_cur) begin
          state_d = REPORT;
          ch_d    = cur_q;
          err_d   = 2'd0;
          data_d  = cnt_q;
        end else if (pluse_us) begin
          if (cnt_q == TO_LAST) begin
            state_d = REPORT;
            ch_d    = cur_q;
            err_d   = 2'd3;
            data_d  = TO_VAL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      REPORT: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        if (pluse_us) begin
          if (cnt_q == GAP_LAST) begin
            if (hi_found) begin
              state_d = CHECK;
              cur_d   = hi_idx;
            end else if (cont_en && (ch_mask != '0)) begin
              state_d = CHECK;
              mask_d  = ch_mask;
              cur_d   = lo_idx;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= IDLE;
      e1_q    <= '0;
      es_q    <= '0;
      esp_q   <= '0;
      mask_q  <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
      err_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      e1_q    <= echo;
      es_q    <= e1_q;
      esp_q   <= es_q;
      mask_q  <= mask_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    trig = '0;
    if (state_q == TRIG) trig[cur_ix] = 1'b1;
  end

  assign busy         = (state_q != IDLE);
  assign done_measure = (state_q == REPORT);
  assign ch_measure   = ch_q;
  assign err_measure  = err_q;
  assign data_measure = data_q;

endmodule

// File: tb/tb_sonar_scan.sv
// Directed bench for sonar_scan: a behavioural sensor answers each trigger and
// a scoreboard checks every reported result in order.
module tb_sonar_scan;

  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int TO  = 400;

  logic           clk_sys = 1'b0;
  logic           rst = 1'b1;
  logic           pluse_us = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic           fire_measure = 1'b0;
  logic           cont_en = 1'b0;
  logic [NCH-1:0] trig;
  logic [NCH-1:0] echo;
  logic [NCH-1:0] echo_sns;
  logic [NCH-1:0] echo_stuck = '0;
  logic           busy, done_measure;
  logic [2:0]     ch_measure;
  logic [1:0]     err_measure;
  logic [W-1:0]   data_measure;

  typedef struct {int ch; int err; int data;} exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int ndone  = 0;
  int width [NCH];
  int trig_cnt [NCH];
  int base [NCH];
  logic [NCH-1:0] trig_prev = '0;
  int done_base;

  assign echo = echo_sns | echo_stuck;

  sonar_scan #(.NCH(NCH), .W(W), .TRIG_US(10), .TIMEOUT_US(TO), .GAP_US(20)) dut (
    .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us), .ch_mask(ch_mask),
    .fire_measure(fire_measure), .cont_en(cont_en), .trig(trig), .echo(echo),
    .busy(busy), .done_measure(done_measure), .ch_measure(ch_measure),
    .err_measure(err_measure), .data_measure(data_measure));

  always #5 clk_sys = ~clk_sys;

  initial begin : strobe
    int div;
    div = 0;
    forever begin
      @(negedge clk_sys);
      div = (div == 3) ? 0 : div + 1;
      pluse_us = (div == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sensor: after each trigger falls, echo rises 20 cycles later for width[ch] µs.
  initial begin : sensor
    int ch;
    echo_sns = '0;
    forever begin
      @(negedge clk_sys);
      if (trig != '0) begin
        ch = 0;
        for (int i = 0; i < NCH; i++) if (trig[i]) ch = i;
        while (trig != '0) @(negedge clk_sys);
        if (width[ch] != 0) begin
          repeat (20) @(negedge clk_sys);
          echo_sns[ch] = 1'b1;
          repeat (4 * width[ch]) @(negedge clk_sys);
          echo_sns[ch] = 1'b0;
        end
      end
    end
  end

  initial begin : trig_mon
    forever begin
      @(negedge clk_sys);
      for (int i = 0; i < NCH; i++)
        if (trig[i] === 1'b1 && trig_prev[i] !== 1'b1) trig_cnt[i]++;
      trig_prev = trig;
    end
  end

  initial begin : scoreboard
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (rst === 1'b0 && done_measure === 1'b1) begin
        ndone++;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("res_ch", 32'(ch_measure), 32'(e.ch));
          check("res_err", 32'(err_measure), 32'(e.err));
          checks++;
          assert (int'(data_measure) + 1 >= e.data && int'(data_measure) <= e.data + ((e.err == 0) ? 1 : 0)) else begin
            errors++;
            $error("FAIL res_data: observed %0d expected %0d", data_measure, e.data);
          end
        end
      end
    end
  end

  task automatic push(input int ch, input int err, input int data);
    exp_t e;
    e.ch = ch; e.err = err; e.data = data;
    sb.push_back(e);
  endtask

  task automatic fire();
    @(negedge clk_sys); fire_measure = 1'b1;
    @(negedge clk_sys); fire_measure = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk_sys);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_trig(input int ch, input int budget);
    int n;
    n = 0;
    while (trig[ch] !== 1'b1 && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    check("trig_wait", 32'(trig[ch]), 32'd1);
  endtask

  task automatic snap();
    for (int i = 0; i < NCH; i++) base[i] = trig_cnt[i];
  endtask

  task automatic trig_delta(input int ch, input int exp);
    check($sformatf("trig_count_ch%0d", ch), 32'(trig_cnt[ch] - base[ch]), 32'(exp));
  endtask

  initial begin : stim
    for (int i = 0; i < NCH; i++) begin width[i] = 0; trig_cnt[i] = 0; end
    repeat (4) @(negedge clk_sys);
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_measure), 32'd0);
    check("rst_ch", 32'(ch_measure), 32'd0);
    check("rst_err", 32'(err_measure), 32'd0);
    check("rst_data", 32'(data_measure), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk_sys);

    // Two enabled channels, normal echoes.
    width[0] = 58; width[2] = 120;
    ch_mask = 4'b0101;
    push(0, 0, 58); push(2, 0, 120);
    snap();
    fire();
    check("busy_t1", 32'(busy), 32'd1);
    @(negedge clk_sys);
    check("trig_t2", 32'(trig), 32'b0001);
    wait_idle("idle_a", 4000);
    for (int i = 0; i < NCH; i++) trig_delta(i, (i == 0 || i == 2) ? 1 : 0);
    check("sb_empty_a", 32'(sb.size()), 32'd0);

    // No rise on ch1, scan continues to ch2.
    width[1] = 0; width[2] = 30;
    ch_mask = 4'b0110;
    push(1, 2, 0); push(2, 0, 30);
    fire();
    wait_idle("idle_b", 6000);
    check("sb_empty_b", 32'(sb.size()), 32'd0);

    // Stuck-high echo on ch0, overlong echo on ch1.
    echo_stuck[0] = 1'b1;
    width[1] = TO + 50;
    repeat (5) @(negedge clk_sys);
    ch_mask = 4'b0011;
    push(0, 1, 0); push(1, 3, TO);
    snap();
    fire();
    wait_idle("idle_c", 6000);
    trig_delta(0, 0);
    trig_delta(1, 1);
    check("sb_empty_c", 32'(sb.size()), 32'd0);
    echo_stuck[0] = 1'b0;
    repeat (400) @(negedge clk_sys);

    // Continuous mode, dropped during the third round's ch0.
    width[0] = 10; width[1] = 15;
    ch_mask = 4'b0011;
    for (int r = 0; r < 3; r++) begin push(0, 0, 10); push(1, 0, 15); end
    done_base = ndone;
    @(negedge clk_sys); cont_en = 1'b1;
    begin
      int n;
      n = 0;
      while (ndone - done_base < 4 && n < 8000) begin @(negedge clk_sys); n++; end
      check("cont_four", 32'(ndone - done_base), 32'd4);
    end
    wait_trig(0, 2000);
    cont_en = 1'b0;
    wait_idle("idle_d", 4000);
    check("cont_total", 32'(ndone - done_base), 32'd6);
    check("sb_empty_d", 32'(sb.size()), 32'd0);

    // Fire while busy is ignored.
    width[0] = 20;
    ch_mask = 4'b0001;
    push(0, 0, 20);
    done_base = ndone;
    fire();
    repeat (60) @(negedge clk_sys);
    fire();
    wait_idle("idle_e", 3000);
    repeat (40) @(negedge clk_sys);
    check("busy_after_e", 32'(busy), 32'd0);
    check("one_result_e", 32'(ndone - done_base), 32'd1);
    check("sb_empty_e", 32'(sb.size()), 32'd0);

    // Empty mask: request ignored.
    ch_mask = 4'b0000;
    fire();
    check("mask0_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk_sys);
    check("mask0_busy_late", 32'(busy), 32'd0);

    // Reset while trig is high, then a normal round.
    ch_mask = 4'b0001;
    done_base = ndone;
    fire();
    wait_trig(0, 100);
    rst = 1'b1;
    @(negedge clk_sys);
    check("mrst_trig", 32'(trig), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done_measure), 32'd0);
    check("mrst_ch", 32'(ch_measure), 32'd0);
    check("mrst_err", 32'(err_measure), 32'd0);
    check("mrst_data", 32'(data_measure), 32'd0);
    @(negedge clk_sys); rst = 1'b0;
    repeat (200) @(negedge clk_sys);
    check("mrst_no_done", 32'(ndone - done_base), 32'd0);
    push(0, 0, 20);
    fire();
    check("refire_busy", 32'(busy), 32'd1);
    wait_idle("idle_f", 3000);
    check("sb_empty_f", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
